dif_butterfly_unit: RTL and testbench

DIF_BUTTERFLY_UNIT -- requirements
Module: dif_butterfly_unit

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/dif_butterfly_unit_if.sv | 25 ++
 rtl/complex_mult_q610.sv | 79 +++++++
 rtl/dif_butterfly_unit.sv | 106 ++++++++++
 tb/tb_dif_butterfly_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared Q6.10 complex fixed-point types, rounding and narrowing helpers for the FFT butterflies.
// Narrowing saturates when DIF_BFLY_SAT_EN is defined, otherwise wraps to the low 16 bits.
package fft_pkg;

    localparam int unsigned FRAC_BITS = 10;
    localparam int unsigned CW        = 16;
    localparam int unsigned WIDE_W    = 2 * CW + 2;

    localparam logic signed [WIDE_W-1:0] CMP_MAX = 34'sd32767;
    localparam logic signed [WIDE_W-1:0] CMP_MIN = -34'sd32768;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } cplx_t;

    // Add half an LSB then shift: ties round toward +inf.
    function automatic logic signed [WIDE_W-1:0] round_shr(
        input logic signed [WIDE_W-1:0] x,
        input int unsigned              fb
    );
        logic signed [WIDE_W-1:0] half;
        half = {{(WIDE_W-1){1'b0}}, 1'b1} << (fb - 1);
        return (x + half) >>> fb;
    endfunction

    function automatic logic [CW-1:0] narrow(input logic signed [WIDE_W-1:0] x);
`ifdef DIF_BFLY_SAT_EN
        if (x > CMP_MAX) begin
            return 16'h7FFF;
        end else if (x < CMP_MIN) begin
            return 16'h8000;
        end else begin
            return x[CW-1:0];
        end
`else
        return x[CW-1:0];
`endif
    endfunction

endpackage

// File: rtl/dif_butterfly_unit_if.sv
// Valid/ready bundle for the DIF butterfly: A/B/w request side and Y/Z result side.
interface dif_butterfly_unit_if;
    import fft_pkg::*;

    logic  in_valid;
    logic  in_ready;
    cplx_t A;
    cplx_t B;
    cplx_t w;
    logic  out_valid;
    logic  out_ready;
    cplx_t Y;
    cplx_t Z;

    modport master (
        output in_valid, A, B, w, out_ready,
        input  in_ready, out_valid, Y, Z
    );

    modport slave (
        input  in_valid, A, B, w, out_ready,
        output in_ready, out_valid, Y, Z
    );

endinterface

// File: rtl/complex_mult_q610.sv
// Two-stage pipelined complex multiply (17-bit D by Q6.10 twiddle) with rounding and narrowing.
// Carries an opaque sideband word alongside so callers can keep companion data aligned.
module complex_mult_q610
    import fft_pkg::*;
#(
    parameter int unsigned FRAC_BITS = fft_pkg::FRAC_BITS,
    parameter int unsigned SIDE_W    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic signed [CW:0]  d_re_i,
    input  logic signed [CW:0]  d_im_i,
    input  cplx_t               w_i,
    input  logic [SIDE_W-1:0]   side_i,
    output logic                valid_o,
    output cplx_t               z_o,
    output logic [SIDE_W-1:0]   side_o
);

    localparam int unsigned PW = 2 * CW + 1;

    logic                     v2_q;
    logic signed [PW-1:0]     pp_rr_q;
    logic signed [PW-1:0]     pp_ii_q;
    logic signed [PW-1:0]     pp_ri_q;
    logic signed [PW-1:0]     pp_ir_q;
    logic [SIDE_W-1:0]        side2_q;

    logic                     v3_q;
    cplx_t                    z_q;
    cplx_t                    z_d;
    logic [SIDE_W-1:0]        side3_q;

    logic signed [WIDE_W-1:0] zr_full;
    logic signed [WIDE_W-1:0] zi_full;

    always_comb begin
        zr_full = WIDE_W'(pp_rr_q) - WIDE_W'(pp_ii_q);
        zi_full = WIDE_W'(pp_ri_q) + WIDE_W'(pp_ir_q);
        z_d.re  = narrow(round_shr(zr_full, FRAC_BITS));
        z_d.im  = narrow(round_shr(zi_full, FRAC_BITS));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2_q    <= 1'b0;
            pp_rr_q <= '0;
            pp_ii_q <= '0;
            pp_ri_q <= '0;
            pp_ir_q <= '0;
            side2_q <= '0;
            v3_q    <= 1'b0;
            z_q     <= '0;
            side3_q <= '0;
        end else if (en_i) begin
            v2_q <= valid_i;
            if (valid_i) begin
                pp_rr_q <= $signed(d_re_i) * $signed(w_i.re);
                pp_ii_q <= $signed(d_im_i) * $signed(w_i.im);
                pp_ri_q <= $signed(d_re_i) * $signed(w_i.im);
                pp_ir_q <= $signed(d_im_i) * $signed(w_i.re);
                side2_q <= side_i;
            end
            // Output register only loads on a real result so bubbles leave Y/Z untouched.
            v3_q <= v2_q;
            if (v2_q) begin
                z_q     <= z_d;
                side3_q <= side2_q;
            end
        end
    end

    assign valid_o = v3_q;
    assign z_o     = z_q;
    assign side_o  = side3_q;

endmodule

// File: rtl/dif_butterfly_unit.sv
// Decimation-in-frequency radix-2 butterfly: Y = A + B, Z = (A - B) * w, three-cycle pipeline.
// Output narrowing controlled by DIF_BFLY_SAT_EN (saturate when defined, wrap otherwise).
module dif_butterfly_unit
    import fft_pkg::*;
#(
    parameter int unsigned FRAC_BITS = fft_pkg::FRAC_BITS,
    parameter int unsigned LATENCY   = 3
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Y,
    output logic [31:0] Z
);

    if (LATENCY != 3) begin : g_latency_fixed
        $error("dif_butterfly_unit: LATENCY is fixed at 3");
    end

    localparam int unsigned SW = 2 * (CW + 1);

    cplx_t                a_in;
    cplx_t                b_in;
    logic                 stall;

    logic signed [CW:0]   sum_re_d;
    logic signed [CW:0]   sum_im_d;
    logic signed [CW:0]   dif_re_d;
    logic signed [CW:0]   dif_im_d;

    logic                 v1_q;
    logic signed [CW:0]   sum_re_q;
    logic signed [CW:0]   sum_im_q;
    logic signed [CW:0]   dif_re_q;
    logic signed [CW:0]   dif_im_q;
    cplx_t                w1_q;

    logic [SW-1:0]        side_out;
    logic signed [CW:0]   y_re;
    logic signed [CW:0]   y_im;
    cplx_t                z_out;

    assign a_in = A;
    assign b_in = B;

    // Global stall: every stage freezes while the output is held.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        sum_re_d = {a_in.re[CW-1], a_in.re} + {b_in.re[CW-1], b_in.re};
        sum_im_d = {a_in.im[CW-1], a_in.im} + {b_in.im[CW-1], b_in.im};
        dif_re_d = {a_in.re[CW-1], a_in.re} - {b_in.re[CW-1], b_in.re};
        dif_im_d = {a_in.im[CW-1], a_in.im} - {b_in.im[CW-1], b_in.im};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            v1_q     <= 1'b0;
            sum_re_q <= '0;
            sum_im_q <= '0;
            dif_re_q <= '0;
            dif_im_q <= '0;
            w1_q     <= '0;
        end else if (!stall) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sum_re_q <= sum_re_d;
                sum_im_q <= sum_im_d;
                dif_re_q <= dif_re_d;
                dif_im_q <= dif_im_d;
                w1_q     <= w;
            end
        end
    end

    complex_mult_q610 #(
        .FRAC_BITS (FRAC_BITS),
        .SIDE_W    (SW)
    ) u_cmul (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .en_i    (~stall),
        .valid_i (v1_q),
        .d_re_i  (dif_re_q),
        .d_im_i  (dif_im_q),
        .w_i     (w1_q),
        .side_i  ({sum_re_q, sum_im_q}),
        .valid_o (out_valid),
        .z_o     (z_out),
        .side_o  (side_out)
    );

    // Y sums ride the multiplier pipeline at full 17 bits and are narrowed off the final register.
    assign y_re = side_out[SW-1:CW+1];
    assign y_im = side_out[CW:0];
    assign Y    = {narrow(WIDE_W'(y_re)), narrow(WIDE_W'(y_im))};
    assign Z    = z_out;

endmodule

// File: tb/tb_dif_butterfly_unit.sv
// Directed-vector bench for dif_butterfly_unit: latency, rounding, narrowing, stall and mid-flight reset.
module tb_dif_butterfly_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    dif_butterfly_unit_if bus();

    dif_butterfly_unit #(.FRAC_BITS(10)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .A         (bus.A),
        .B         (bus.B),
        .w         (bus.w),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .Y         (bus.Y),
        .Z         (bus.Z)
    );

    always #5 clk = ~clk;

    // Stall-burst table: B = (0x40, 0x100), w = j, so Y = A + B and Z = (-(Ai - 0x100), Ar - 0x40).
    localparam logic [31:0] SV_B = 32'h0040_0100;
    localparam logic [31:0] SV_W = 32'h0000_0400;
    logic [31:0] sv_a [8] = '{32'h0100_0010, 32'h0200_0020, 32'h0300_0030, 32'h0400_0040,
                              32'h0500_0050, 32'h0600_0060, 32'h0700_0070, 32'h0800_0080};
    logic [31:0] sv_y [8] = '{32'h0140_0110, 32'h0240_0120, 32'h0340_0130, 32'h0440_0140,
                              32'h0540_0150, 32'h0640_0160, 32'h0740_0170, 32'h0840_0180};
    logic [31:0] sv_z [8] = '{32'h00F0_00C0, 32'h00E0_01C0, 32'h00D0_02C0, 32'h00C0_03C0,
                              32'h00B0_04C0, 32'h00A0_05C0, 32'h0090_06C0, 32'h0080_07C0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ww);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.w        = ww;
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ww, input logic [31:0] ey, input logic [31:0] ez);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, ww);
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        chk({tag, ".early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".Y"}, bus.Y, ey);
        chk({tag, ".Z"}, bus.Z, ez);
        @(negedge clk);
        chk({tag, ".drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ovf_y;
        logic [31:0] zpos_ovf;
        logic [31:0] zneg_ovf;
        int in_idx;
        int out_idx;
`ifdef DIF_BFLY_SAT_EN
        ovf_y    = 32'h7FFF_0000;
        zpos_ovf = 32'h7FFF_0000;
        zneg_ovf = 32'h0000_8000;
`else
        ovf_y    = 32'h8000_0000;
        zpos_ovf = 32'h8000_0000;
        zneg_ovf = 32'h0000_4000;
`endif
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        #12;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.Y", bus.Y, 32'h0);
        chk("rst.Z", bus.Z, 32'h0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_one("basic",   32'h0400_0000, 32'h0200_0000, 32'h0000_0400, 32'h0600_0000, 32'h0000_0200);
        run_one("ovf_y",   32'h7FFF_0000, 32'h0001_0000, 32'h0400_0000, ovf_y,         32'h7FFE_0000);
        run_one("ovf_zp",  32'h4000_0000, 32'hC000_0000, 32'h0400_0000, 32'h0000_0000, zpos_ovf);
        run_one("ovf_zn",  32'h0000_8000, 32'h0000_4000, 32'h0400_0000, 32'h0000_C000, zneg_ovf);
        run_one("rnd_pos", 32'h0001_0000, 32'h0000_0000, 32'h0200_0000, 32'h0001_0000, 32'h0001_0000);
        run_one("rnd_neg", 32'hFFFF_0000, 32'h0000_0000, 32'h0200_0000, 32'hFFFF_0000, 32'h0000_0000);
        run_one("rnd_h3",  32'hFFFD_0000, 32'h0000_0000, 32'h0200_0000, 32'hFFFD_0000, 32'hFFFF_0000);
        run_one("cross",   32'h0400_0200, 32'h0100_0300, 32'h0200_0200, 32'h0500_0500, 32'h0200_0100);

        // Back-to-back burst with out_ready dropped on cycles 4..6.
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 1; cyc <= 40 && out_idx < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 4 && cyc <= 6);
            if (in_idx < 8) drive(1'b1, sv_a[in_idx], SV_B, SV_W);
            else            drive(1'b0, '0, '0, '0);
            #1;
            chk($sformatf("burst.in_ready.c%0d", cyc), 32'(bus.in_ready),
                32'(!(cyc >= 4 && cyc <= 6)));
            if (cyc >= 4 && cyc <= 6) begin
                chk($sformatf("stall.out_valid.c%0d", cyc), 32'(bus.out_valid), 32'd1);
                chk($sformatf("stall.Y.c%0d", cyc), bus.Y, sv_y[out_idx]);
                chk($sformatf("stall.Z.c%0d", cyc), bus.Z, sv_z[out_idx]);
            end else if (bus.out_valid) begin
                chk($sformatf("burst.Y%0d", out_idx), bus.Y, sv_y[out_idx]);
                chk($sformatf("burst.Z%0d", out_idx), bus.Z, sv_z[out_idx]);
                out_idx++;
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
        end
        chk("burst.count", 32'(out_idx), 32'd8);
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("burst.idle", 32'(bus.out_valid), 32'd0);
        end

        // Reset with one result on the output and two more in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, sv_a[i], SV_B, SV_W);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        #1;
        chk("mid.pre_valid", 32'(bus.out_valid), 32'd1);
        chk("mid.pre_Y", bus.Y, sv_y[0]);
        #1 rst = 1'b1;
        #1;
        chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid.Y", bus.Y, 32'h0);
        chk("mid.Z", bus.Z, 32'h0);
        chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post.no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_one("post", 32'h0400_0200, 32'h0100_0300, 32'h0200_0200, 32'h0500_0500, 32'h0200_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
